// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes, E/M payload.
package execute_stage_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    // Contents of the E/M pipeline register
    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic              zero;
        logic [DATA_W-1:0] branch_target;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] pc;
    } em_payload_t;

endpackage

// File: rtl/execute_stage_alu_core.sv
// Combinational 32-bit ALU.
//   a_i, b_i  : operands
//   op_i      : operation select
//   result_c  : ALU result
//   zero_c    : result == 0
module execute_stage_alu_core
    import execute_stage_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] result_c,
    output logic              zero_c
);

    always_comb begin
        result_c = '0;
        unique case (op_i)
            ALU_ADD: result_c = a_i + b_i;
            ALU_SUB: result_c = a_i - b_i;
            ALU_AND: result_c = a_i & b_i;
            ALU_OR:  result_c = a_i | b_i;
            ALU_XOR: result_c = a_i ^ b_i;
            ALU_SLT: result_c = DATA_W'($signed(a_i) < $signed(b_i));
            // Only the low bits of B form the shift amount
            ALU_SLL: result_c = a_i << b_i[SHAMT_W-1:0];
            ALU_SRL: result_c = a_i >> b_i[SHAMT_W-1:0];
            default: result_c = '0;
        endcase
    end

    assign zero_c = (result_c == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand-B select, ALU, branch target adder, E/M register.
//   clk, reset     : rising-edge clock, async active-low reset
//   dhit           : stage enable (data-cache hit), 0 holds the E/M register
//   pcDE .. AluControlE : decode/execute stage inputs
//   ALUOutM .. pcEM     : registered E/M outputs
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dhit,
    input  logic [DATA_W-1:0] pcDE,
    input  logic [DATA_W-1:0] SrcAE,
    input  logic [DATA_W-1:0] rd2E,
    input  logic [DATA_W-1:0] SignImmE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [REG_W-1:0]  WriteRegE,
    input  logic              ALUSrcE,
    input  logic [OP_W-1:0]   AluControlE,
    output logic [DATA_W-1:0] ALUOutM,
    output logic              ZeroM,
    output logic [DATA_W-1:0] BranchTargetM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_W-1:0]  WriteRegM,
    output logic [DATA_W-1:0] pcEM
);

    logic [DATA_W-1:0] src_b_c;
    logic [DATA_W-1:0] alu_result_c;
    logic              alu_zero_c;
    logic [DATA_W-1:0] target_c;
    em_payload_t       em_d;
    em_payload_t       em_q;

    assign src_b_c  = ALUSrcE ? SignImmE : rd2E;
    // Immediate is already a byte offset; no shift before the add
    assign target_c = pcDE + SignImmE;

    execute_stage_alu_core u_alu (
        .a_i      (SrcAE),
        .b_i      (src_b_c),
        .op_i     (alu_op_e'(AluControlE)),
        .result_c (alu_result_c),
        .zero_c   (alu_zero_c)
    );

    // Whole-stage load on dhit, otherwise hold
    always_comb begin
        em_d = em_q;
        if (dhit) begin
            em_d.alu_out       = alu_result_c;
            em_d.zero          = alu_zero_c;
            em_d.branch_target = target_c;
            em_d.write_data    = WriteDataE;
            em_d.write_reg     = WriteRegE;
            em_d.pc            = pcDE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            em_q <= '0;
        end else begin
            em_q <= em_d;
        end
    end

    assign ALUOutM       = em_q.alu_out;
    assign ZeroM         = em_q.zero;
    assign BranchTargetM = em_q.branch_target;
    assign WriteDataM    = em_q.write_data;
    assign WriteRegM     = em_q.write_reg;
    assign pcEM          = em_q.pc;

endmodule

// File: tb/tb_execute_stage.sv
// Directed + random bench for execute_stage with an expected-result queue.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        dhit;
    logic [31:0] pcDE, SrcAE, rd2E, SignImmE, WriteDataE;
    logic [4:0]  WriteRegE;
    logic        ALUSrcE;
    logic [2:0]  AluControlE;
    logic [31:0] ALUOutM, BranchTargetM, WriteDataM, pcEM;
    logic        ZeroM;
    logic [4:0]  WriteRegM;

    int tests = 0;
    int fails = 0;
    em_payload_t sb_q[$];
    em_payload_t last_exp;

    execute_stage dut (
        .clk           (clk),
        .reset         (reset),
        .dhit          (dhit),
        .pcDE          (pcDE),
        .SrcAE         (SrcAE),
        .rd2E          (rd2E),
        .SignImmE      (SignImmE),
        .WriteDataE    (WriteDataE),
        .WriteRegE     (WriteRegE),
        .ALUSrcE       (ALUSrcE),
        .AluControlE   (AluControlE),
        .ALUOutM       (ALUOutM),
        .ZeroM         (ZeroM),
        .BranchTargetM (BranchTargetM),
        .WriteDataM    (WriteDataM),
        .WriteRegM     (WriteRegM),
        .pcEM          (pcEM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic em_payload_t mk(input logic [31:0] alu, input logic z,
                                       input logic [31:0] bt, input logic [31:0] wd,
                                       input logic [4:0] wr, input logic [31:0] pc);
        em_payload_t p;
        p.alu_out       = alu;
        p.zero          = z;
        p.branch_target = bt;
        p.write_data    = wd;
        p.write_reg     = wr;
        p.pc            = pc;
        return p;
    endfunction

    // Reference model built from the operation table
    function automatic em_payload_t model();
        logic [31:0] b, r;
        logic        lt;
        b = ALUSrcE ? SignImmE : rd2E;
        case (AluControlE)
            3'd0: r = SrcAE + b;
            3'd1: r = SrcAE + ~b + 32'd1;
            3'd2: r = SrcAE & b;
            3'd3: r = SrcAE | b;
            3'd4: r = SrcAE ^ b;
            3'd5: begin
                lt = (SrcAE[31] != b[31]) ? SrcAE[31] : (SrcAE < b);
                r  = {31'd0, lt};
            end
            3'd6: r = SrcAE << b[4:0];
            default: r = SrcAE >> b[4:0];
        endcase
        return mk(r, (r == 32'd0), pcDE + SignImmE, WriteDataE, WriteRegE, pcDE);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input em_payload_t e);
        check({tag, ".ALUOutM"},       ALUOutM,            e.alu_out);
        check({tag, ".ZeroM"},         32'(ZeroM),         32'(e.zero));
        check({tag, ".BranchTargetM"}, BranchTargetM,      e.branch_target);
        check({tag, ".WriteDataM"},    WriteDataM,         e.write_data);
        check({tag, ".WriteRegM"},     32'(WriteRegM),     32'(e.write_reg));
        check({tag, ".pcEM"},          pcEM,               e.pc);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [31:0] wd, input logic [4:0] wr,
                         input logic src, input logic [2:0] op);
        pcDE = pc; SrcAE = a; rd2E = r2; SignImmE = imm;
        WriteDataE = wd; WriteRegE = wr; ALUSrcE = src; AluControlE = op;
    endtask

    // Clock one enabled edge and compare against the oldest queued expectation
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            last_exp = sb_q.pop_front();
            check_all(tag, last_exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        dhit  = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0);
        #2;
        check_all("reset", mk(32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        dhit  = 1'b1;

        drive(32'h40, 32'd5, 32'd7, 32'h0, 32'hAA, 5'd3, 1'b0, 3'b000);
        sb_q.push_back(mk(32'd12, 1'b0, 32'h40, 32'hAA, 5'd3, 32'h40));
        step("add");

        drive(32'h44, 32'h1234, 32'h1234, 32'h4, 32'hBB, 5'd4, 1'b0, 3'b001);
        sb_q.push_back(mk(32'd0, 1'b1, 32'h48, 32'hBB, 5'd4, 32'h44));
        step("sub_eq");

        drive(32'h48, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h0, 5'd5, 1'b0, 3'b101);
        sb_q.push_back(mk(32'd1, 1'b0, 32'h50, 32'h0, 5'd5, 32'h48));
        step("slt");

        drive(32'h4C, 32'h8000_0000, 32'd31, 32'h0, 32'h1, 5'd6, 1'b0, 3'b111);
        sb_q.push_back(mk(32'd1, 1'b0, 32'h4C, 32'h1, 5'd6, 32'h4C));
        step("srl");

        drive(32'h50, 32'd3, 32'h21, 32'h0, 32'h2, 5'd7, 1'b0, 3'b110);
        sb_q.push_back(mk(32'd6, 1'b0, 32'h50, 32'h2, 5'd7, 32'h50));
        step("sll_mask");

        drive(32'h100, 32'd16, 32'd99, 32'hFFFF_FFFC, 32'hCAFE, 5'd8, 1'b1, 3'b000);
        sb_q.push_back(mk(32'd12, 1'b0, 32'hFC, 32'hCAFE, 5'd8, 32'h100));
        step("imm");

        drive(32'hFFFF_FFF8, 32'd1, 32'd1, 32'h10, 32'h3, 5'd9, 1'b0, 3'b010);
        sb_q.push_back(mk(32'd1, 1'b0, 32'h8, 32'h3, 5'd9, 32'hFFFF_FFF8));
        step("wrap");

        // Stall: new inputs must not leak into any output
        dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h200 + 32'(i), 32'h55 + 32'(i), 32'd1, 32'h4, 32'h77, 5'(20 + i), 1'b0, 3'b011);
            @(posedge clk);
            #1;
            check_all("stall", last_exp);
        end
        dhit = 1'b1;
        drive(32'h300, 32'hF0, 32'h0F, 32'h20, 32'h99, 5'd11, 1'b0, 3'b100);
        sb_q.push_back(mk(32'hFF, 1'b0, 32'h320, 32'h99, 5'd11, 32'h300));
        step("unstall");

        // Random mix against the model
        for (int i = 0; i < 12; i++) begin
            drive($urandom, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  $urandom, $urandom, 5'($urandom), 1'($urandom), 3'(i % 8));
            if (i % 4 == 1) rd2E = SrcAE;
            sb_q.push_back(model());
            step("rand");
        end

        // Async reset between edges
        #3;
        reset = 1'b0;
        #1;
        check_all("async_reset", mk(32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0));
        dhit = 1'b1;
        drive(32'h400, 32'd1, 32'd2, 32'h4, 32'h5, 5'd5, 1'b0, 3'b000);
        @(posedge clk);
        #1;
        check_all("reset_wins", mk(32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0));

        // Reset released during a stall: stays cleared until an enabled edge
        dhit  = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("stall_after_reset", mk(32'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0));
        dhit = 1'b1;
        sb_q.push_back(mk(32'd3, 1'b0, 32'h404, 32'h5, 5'd5, 32'h400));
        step("first_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipelined processor: selects the ALU second operand, performs the 32-bit ALU operation, computes the branch/jump target from the execute-stage PC and immediate, and registers results into the E/M pipeline register. Sits between the decode/execute register and the memory stage; the register advances only while the data cache reports a hit.

## Interface
Parameters: none (32-bit datapath, 5-bit register index fixed).

Ports:
- clk  in  1  pipeline clock, rising-edge
- reset  in  1  asynchronous, active-low; clears E/M register
- dhit  in  1  stage enable (data-cache hit); 0 = hold
- pcDE  in  32  PC of instruction in execute
- SrcAE  in  32  ALU operand A (rs1 value)
- rd2E  in  32  rs2 value
- SignImmE  in  32  sign-extended immediate
- WriteDataE  in  32  store data
- WriteRegE  in  5  destination register index
- ALUSrcE  in  1  0: SrcB = rd2E, 1: SrcB = SignImmE
- AluControlE  in  3  ALU operation
- ALUOutM  out  32  registered ALU result
- ZeroM  out  1  registered zero flag
- BranchTargetM  out  32  registered pcDE + SignImmE
- WriteDataM  out  32  registered store data
- WriteRegM  out  5  registered destination index
- pcEM  out  32  registered PC

## Operation
- SrcB = ALUSrcE ? SignImmE : rd2E.
- AluControlE: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1/0), 110 SLL (A << B[4:0]), 111 SRL logical (A >> B[4:0]).
- ADD/SUB modulo 2^32, no overflow flag.
- zero = (ALU result == 0), combinational from current result.
- Branch target = pcDE + SignImmE, modulo 2^32; immediate already a byte offset, no shift.
- All combinational paths purely functions of current inputs; no internal state other than the E/M register.

## Timing
- reset low (any time, async): ALUOutM, BranchTargetM, WriteDataM, pcEM = 0; ZeroM = 0; WriteRegM = 0. Held while low.
- reset high, rising clk, dhit=1: all six outputs load their E-stage values; latency 1 cycle.
- dhit=0: all outputs hold previous values (full-stage stall, no partial update).
- reset deasserted mid-stall: outputs stay 0 until first enabled edge.
- Simultaneous reset low and dhit=1: reset wins.

## Structure
- Shared package: ALU opcode constants (ALU_ADD … ALU_SRL), data width 32, register-index width 5.
- One sub-module natural: alu_core (combinational: A, B, op → result, zero). Operand mux, target adder and E/M register live in execute_stage.

## Test plan
- ADD: SrcAE=5, rd2E=7, ALUSrcE=0, op=000, dhit=1, edge → ALUOutM=12, ZeroM=0.
- SUB equal: SrcAE=rd2E=0x1234, op=001 → ALUOutM=0, ZeroM=1; SLT: A=0xFFFFFFFF, B=1 → 1; SRL: A=0x80000000, B=31 → 1; SLL with B=0x21 → shift by 1.
- Immediate select: ALUSrcE=1, SignImmE=0xFFFFFFFC, SrcAE=16, op=000 → ALUOutM=12; pcDE=0x100 → BranchTargetM=0xFC, pcEM=0x100.
- Stall: load values, then dhit=0 with new inputs for 3 edges → all outputs unchanged; dhit=1 → new values next edge.
- Async reset: drop reset between edges → all outputs 0 immediately; WriteRegE=5 with reset low at edge → WriteRegM stays 0.
- Wrap: pcDE=0xFFFFFFF8, SignImmE=0x10 → BranchTargetM=0x8.
